// File: rtl/mxv_input_loader_pkg.sv
// Shared definitions for the matrix-vector input loader.
//   DATA_W / MAX_N / NUM_PROC : default element width, largest matrix order,
//                               number of processor (matrix) FIFOs
//   loader_state_t            : loader FSM states
//   loader_err_t              : sticky error flags {chk, ovf, bad_n}
package mxv_input_loader_pkg;
  localparam int DATA_W   = 8;
  localparam int MAX_N    = 8;
  localparam int NUM_PROC = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_V,
    ST_GET_M,
    ST_CHK,
    ST_REPLAY_V,
    ST_START,
    ST_WAIT_DONE
  } loader_state_t;

  typedef struct packed {
    logic chk;
    logic ovf;
    logic bad_n;
  } loader_err_t;
endpackage

// File: rtl/mxv_vector_buffer.sv
// Holds the received vector so it can be pushed to the vector FIFO a second
// time without the host resending it.
//   clk, reset      : clock, async active-low reset
//   i_wr_en/addr/data : write port, one element per cycle
//   i_rd_clr        : return the replay pointer to element 0
//   i_rd_adv        : step the replay pointer after the current element is used
//   o_rd_data       : element at the replay pointer
//   o_rd_ptr        : current replay pointer
module mxv_vector_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_clr,
  input  logic              i_rd_adv,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [AW-1:0]     o_rd_ptr
);
  import mxv_input_loader_pkg::*;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [AW-1:0]                r_rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem    <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_clr)      r_rd_ptr <= '0;
      else if (i_rd_adv) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_rd_ptr  = r_rd_ptr;
endmodule

// File: rtl/mxv_input_loader.sv
// Parses the host byte stream (N, vector, matrix rows row-major) and pushes it
// into the processor input FIFOs: row r -> matrix FIFO r % NUM_PROC, vector to
// the vector FIFO (a second time from the buffer when N > NUM_PROC). Then
// pulses start_o and waits for done_i.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//   clk, reset : clock, async active-low reset
//   rx_data/rx_valid : received byte and its one-cycle strobe
//   fifo_full  : [NUM_PROC-1:0] matrix FIFOs full, [NUM_PROC] vector FIFO full
//   done_i     : product fully drained
//   n_o        : latched matrix order
//   wr_data_o, push_v_o, push_m_o : registered FIFO write data and strobes
//   start_o    : one-cycle start to the processor controller
//   ready_o    : high while idle
//   err_o      : sticky {checksum, overflow/unexpected byte, illegal N}
module mxv_input_loader #(
  parameter int DATA_W   = mxv_input_loader_pkg::DATA_W,
  parameter int MAX_N    = mxv_input_loader_pkg::MAX_N,
  parameter int NUM_PROC = mxv_input_loader_pkg::NUM_PROC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic [NUM_PROC:0]   fifo_full,
  input  logic                done_i,
  output logic [3:0]          n_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic                push_v_o,
  output logic [NUM_PROC-1:0] push_m_o,
  output logic                start_o,
  output logic                ready_o,
  output logic [2:0]          err_o
);
  import mxv_input_loader_pkg::*;

  localparam int CW = $clog2(MAX_N);

  loader_state_t       r_state;
  loader_err_t         r_err;
  logic [3:0]          r_n;
  logic [CW-1:0]       r_row, r_col;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_push_v, r_start, r_ready;
  logic [NUM_PROC-1:0] r_push_m;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_chk;
`endif

  logic [3:0]          w_nm1;
  logic                w_n_ok, w_replay, w_col_last, w_row_last, w_rd_last;
  logic [CW-1:0]       w_proc, w_rd_ptr;
  logic [NUM_PROC-1:0] w_proc_oh;
  logic                w_proc_full, w_vec_full;
  logic [DATA_W-1:0]   w_rd_data;

  // Counters are compared against N-1 in 4 bits so N=8 needs no 4th counter bit.
  assign w_nm1       = r_n - 4'd1;
  assign w_n_ok      = (rx_data != '0) && (rx_data <= DATA_W'(MAX_N));
  assign w_replay    = r_n > 4'(NUM_PROC);
  assign w_col_last  = 4'(r_col) == w_nm1;
  assign w_row_last  = 4'(r_row) == w_nm1;
  assign w_rd_last   = 4'(w_rd_ptr) == w_nm1;
  assign w_proc      = r_row % CW'(NUM_PROC);
  assign w_proc_oh   = NUM_PROC'(1) << w_proc;
  assign w_proc_full = |(fifo_full[NUM_PROC-1:0] & w_proc_oh);
  assign w_vec_full  = fifo_full[NUM_PROC];

  mxv_vector_buffer #(.DATA_W(DATA_W), .DEPTH(MAX_N), .AW(CW)) u_vbuf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   ((r_state == ST_GET_V) && rx_valid),
    .i_wr_addr (r_col),
    .i_wr_data (rx_data),
    .i_rd_clr  (r_state == ST_IDLE),
    // a full vector FIFO holds the replay element in place
    .i_rd_adv  ((r_state == ST_REPLAY_V) && !w_vec_full),
    .o_rd_data (w_rd_data),
    .o_rd_ptr  (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_err     <= '0;
      r_n       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_wr_data <= '0;
      r_push_v  <= 1'b0;
      r_push_m  <= '0;
      r_start   <= 1'b0;
      r_ready   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chk     <= '0;
`endif
    end else begin
      r_push_v <= 1'b0;
      r_push_m <= '0;
      r_start  <= 1'b0;
      r_ready  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          r_row   <= '0;
          r_col   <= '0;
          if (rx_valid) begin
            r_n <= rx_data[3:0];
            if (w_n_ok) begin
              r_err   <= '0;
              r_ready <= 1'b0;
              r_state <= ST_GET_V;
`ifdef LOADER_CHECKSUM_EN
              r_chk   <= rx_data;
`endif
            end else begin
              r_err.bad_n <= 1'b1;
            end
          end
        end
        ST_GET_V: if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
          r_chk <= r_chk ^ rx_data;
`endif
          if (w_vec_full) r_err.ovf <= 1'b1;
          else begin
            r_push_v  <= 1'b1;
            r_wr_data <= rx_data;
          end
          // counters advance even on a dropped byte to keep the frame aligned
          if (w_col_last) begin
            r_col   <= '0;
            r_state <= ST_GET_M;
          end else r_col <= r_col + 1'b1;
        end
        ST_GET_M: if (rx_valid) begin
`ifdef LOADER_CHECKSUM_EN
          r_chk <= r_chk ^ rx_data;
`endif
          if (w_proc_full) r_err.ovf <= 1'b1;
          else begin
            r_push_m  <= w_proc_oh;
            r_wr_data <= rx_data;
          end
          if (w_col_last) begin
            r_col <= '0;
            if (w_row_last) begin
              r_row <= '0;
`ifdef LOADER_CHECKSUM_EN
              r_state <= ST_CHK;
`else
              r_state <= w_replay ? ST_REPLAY_V : ST_START;
`endif
            end else r_row <= r_row + 1'b1;
          end else r_col <= r_col + 1'b1;
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: if (rx_valid) begin
          if (rx_data == r_chk) r_state <= w_replay ? ST_REPLAY_V : ST_START;
          else begin
            // pushed data stays behind; the controller wipes its FIFOs
            r_err.chk <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
`endif
        ST_REPLAY_V: begin
          if (rx_valid) r_err.ovf <= 1'b1;
          if (!w_vec_full) begin
            r_push_v  <= 1'b1;
            r_wr_data <= w_rd_data;
            if (w_rd_last) r_state <= ST_START;
          end
        end
        ST_START: begin
          if (rx_valid) r_err.ovf <= 1'b1;
          r_start <= 1'b1;
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (rx_valid) r_err.ovf <= 1'b1;
          if (done_i) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign n_o       = r_n;
  assign wr_data_o = r_wr_data;
  assign push_v_o  = r_push_v;
  assign push_m_o  = r_push_m;
  assign start_o   = r_start;
  assign ready_o   = r_ready;
  assign err_o     = r_err;
endmodule

// File: tb/tb_mxv_input_loader.sv
// Directed bench for mxv_input_loader. A monitor logs every FIFO push; each
// frame's pushes are compared against a list built from the stimulus arrays.
module tb_mxv_input_loader;
  logic       clk = 1'b0, reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [4:0] fifo_full = '0;
  logic       done_i = 1'b0;
  logic [3:0] n_o;
  logic [7:0] wr_data_o;
  logic       push_v_o;
  logic [3:0] push_m_o;
  logic       start_o, ready_o;
  logic [2:0] err_o;

  int checks = 0, failures = 0, nstart = 0, multi = 0;
  logic [7:0]  vq[$];
  logic [11:0] mq[$];
  logic [7:0]  vbuf[8];
  logic [7:0]  mbuf[64];

  always #5 clk = ~clk;

  mxv_input_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .done_i(done_i), .n_o(n_o), .wr_data_o(wr_data_o),
    .push_v_o(push_v_o), .push_m_o(push_m_o), .start_o(start_o),
    .ready_o(ready_o), .err_o(err_o)
  );

  always @(posedge clk) begin
    #2;
    if (push_v_o) vq.push_back(wr_data_o);
    if ($countones(push_m_o) > 1) multi++;
    for (int p = 0; p < 4; p++) if (push_m_o[p]) mq.push_back({4'(p), wr_data_o});
    if (start_o) nstart++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // drop >= 0 raises dmask on fifo_full while matrix byte 'drop' is sent
  task automatic send_frame(input int n, input int drop, input logic [4:0] dmask);
    logic [7:0] x;
    vq.delete(); mq.delete();
    x = 8'(n);
    send(8'(n));
    for (int i = 0; i < n; i++) begin send(vbuf[i]); x ^= vbuf[i]; end
    for (int i = 0; i < n * n; i++) begin
      if (i == drop) fifo_full = dmask;
      send(mbuf[i]); x ^= mbuf[i];
      fifo_full = '0;
    end
`ifdef LOADER_CHECKSUM_EN
    send(x);
`endif
  endtask

  task automatic end_frame(input string tag, input int exp_k);
    int k;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (start_o) begin k = i; break; end
    end
    chk({tag, "_start_lat"}, k, exp_k);
    @(negedge clk);
    chk({tag, "_start_pulse"}, {31'd0, start_o}, 0);
    chk({tag, "_ready_busy"}, {31'd0, ready_o}, 0);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    chk({tag, "_ready_done"}, {31'd0, ready_o}, 1);
  endtask

  task automatic check_pushes(input string tag, input int n, input int drop);
    int bad, idx, ev;
    bad = 0; idx = 0;
    ev = (n > 4) ? 2 * n : n;
    chk({tag, "_vcnt"}, vq.size(), ev);
    for (int i = 0; i < vq.size() && i < ev; i++) if (vq[i] !== vbuf[i % n]) bad++;
    for (int i = 0; i < n * n; i++) if (i != drop) begin
      if (idx < mq.size() && mq[idx] !== {4'((i / n) % 4), mbuf[i]}) bad++;
      idx++;
    end
    chk({tag, "_mcnt"}, mq.size(), idx);
    chk({tag, "_data"}, bad, 0);
  endtask

  initial begin
    int cnt, s;
    // reset
    #1;
    chk("rst_outputs", {10'd0, n_o, wr_data_o, push_v_o, push_m_o, start_o, ready_o, err_o}, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 1);

    // 1: N=3, no replay
    for (int i = 0; i < 3; i++) vbuf[i] = 8'(i + 1);
    for (int i = 0; i < 9; i++) mbuf[i] = 8'(i + 1);
    send_frame(3, -1, '0);
    chk("t1_n", {28'd0, n_o}, 3);
    end_frame("t1", 1);
    check_pushes("t1", 3, -1);

    // 2: N=8, vector replayed
    for (int i = 0; i < 8; i++) vbuf[i] = 8'(8'h10 + i);
    for (int i = 0; i < 64; i++) mbuf[i] = 8'(8'h40 + i);
    send_frame(8, -1, '0);
    end_frame("t2", 9);
    check_pushes("t2", 8, -1);
    cnt = 0;
    foreach (mq[i]) if (mq[i][11:8] == 4'd1) cnt++;
    chk("t2_fifo1_cnt", cnt, 16);
    chk("t2_err", {29'd0, err_o}, 0);

    // 3: illegal N, then recovery
    vq.delete(); mq.delete();
    send(8'd0);
    chk("t3_n0_err", {29'd0, err_o}, 3'b001);
    chk("t3_n0_ready", {31'd0, ready_o}, 1);
    send(8'd9);
    chk("t3_n9_err", {29'd0, err_o}, 3'b001);
    chk("t3_n9_n", {28'd0, n_o}, 9);
    @(negedge clk);
    chk("t3_no_push", vq.size() + mq.size(), 0);
    vbuf[0] = 8'd5; vbuf[1] = 8'd6;
    for (int i = 0; i < 4; i++) mbuf[i] = 8'(i + 1);
    send_frame(2, -1, '0);
    chk("t3_err_clr", {29'd0, err_o}, 0);
    end_frame("t3", 1);
    check_pushes("t3", 2, -1);

    // 4a: N=5, replay stalled 3 cycles by a full vector FIFO
    for (int i = 0; i < 5; i++) vbuf[i] = 8'(8'h61 + i);
    for (int i = 0; i < 25; i++) mbuf[i] = 8'(8'h80 + i);
    send_frame(5, -1, '0);
    fifo_full = 5'b10000;
    repeat (3) @(negedge clk);
    chk("t4_stall_vcnt", vq.size(), 5);
    fifo_full = '0;
    end_frame("t4", 6);
    check_pushes("t4", 5, -1);
    chk("t4_err", {29'd0, err_o}, 0);

    // 4b: matrix FIFO 1 full for the first byte of row 1
    vbuf[0] = 8'd7; vbuf[1] = 8'd8;
    for (int i = 0; i < 4; i++) mbuf[i] = 8'(8'h21 + i);
    send_frame(2, 2, 5'b00010);
    end_frame("t4b", 1);
    check_pushes("t4b", 2, 2);
    chk("t4b_err", {29'd0, err_o}, 3'b010);

    // 5: reset in the middle of GET_M
    send(8'd3);
    for (int i = 0; i < 3; i++) send(8'(i + 1));
    for (int i = 0; i < 4; i++) send(8'(8'h30 + i));
    reset = 1'b0;
    #1;
    chk("t5_rst_outputs", {10'd0, n_o, wr_data_o, push_v_o, push_m_o, start_o, ready_o, err_o}, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("t5_ready", {31'd0, ready_o}, 1);
    vbuf[0] = 8'd3; vbuf[1] = 8'd4;
    for (int i = 0; i < 4; i++) mbuf[i] = 8'(9 + i);
    send_frame(2, -1, '0);
    end_frame("t5", 1);
    check_pushes("t5", 2, -1);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum accept and reject
    send(8'd1); send(8'd5); send(8'd7); send(8'd3);
    end_frame("t6_ok", 1);
    s = nstart;
    send(8'd1); send(8'd5); send(8'd7); send(8'd4);
    chk("t6_bad_err", {29'd0, err_o}, 3'b100);
    chk("t6_bad_ready", {31'd0, ready_o}, 1);
    repeat (4) @(negedge clk);
    chk("t6_no_start", nstart - s, 0);
`else
    s = 0;
`endif

    chk("onehot_push_m", multi + s - s, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
